pulse_seq: RTL

Biphasic stimulation pulse sequencer driven by the frequency prescaler's square-wave output. Each rising edge of the prescaler output is one time base tick. The block counts ticks to generate a programmable train of cathodic/gap/anodic/rest phases. It sits directly downstream of the prescaler and drives the electrode switch-enable lines of the stimulator front-end.

---
 rtl/pulse_seq_pkg.sv | 23 ++
 rtl/pulse_phase_timer.sv | 45 ++++
 rtl/pulse_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared state encoding and phase-skip helper for the pulse sequencer
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CATH,
        ST_GAP,
        ST_ANOD,
        ST_REST
    } state_t;

    // First nonzero phase among CATH(0)/GAP(1)/ANOD(2) at or after from_pos; ST_IDLE if none.
    function automatic state_t first_active(input logic [2:0] nz_cga, input logic [1:0] from_pos);
        state_t r;
        r = ST_IDLE;
        if (from_pos <= 2'd2 && nz_cga[2]) r = ST_ANOD;
        if (from_pos <= 2'd1 && nz_cga[1]) r = ST_GAP;
        if (from_pos == 2'd0 && nz_cga[0]) r = ST_CATH;
        return r;
    endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// rtl/pulse_phase_timer.sv - tick edge detect and per-phase tick counter with end-of-phase compare
module pulse_phase_timer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 run,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 tick,
    output logic                 phase_end
);

    logic                 tick_in_q, tick_in_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last;

    assign tick      = tick_in & ~tick_in_q;
    assign last      = (cnt_q == len - CNT_WIDTH'(1));
    assign phase_end = run & tick & last;

    // Count wraps to 0 on phase end so back-to-back entries of the same phase restart cleanly.
    always_comb begin
        tick_in_d = tick_in;
        cnt_d     = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = last ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_in_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            tick_in_q <= tick_in_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_seq.sv
// rtl/pulse_seq.sv - biphasic pulse train sequencer; PULSE_SEQ_CHARGE_BAL_EN enables start rejection on cath/anod mismatch
module pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int NP_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] cath_len,
    input  logic [CNT_WIDTH-1:0] gap_len,
    input  logic [CNT_WIDTH-1:0] anod_len,
    input  logic [CNT_WIDTH-1:0] rest_len,
    input  logic [NP_WIDTH-1:0]  n_pulses,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 cath_en,
    output logic                 anod_en,
    output logic [NP_WIDTH-1:0]  pulse_idx
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cath_q, cath_d, gap_q, gap_d, anod_q, anod_d, rest_q, rest_d;
    logic [NP_WIDTH-1:0]  n_q, n_d, idx_q, idx_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                 cath_en_q, cath_en_d, anod_en_q, anod_en_d;

    logic                 tick, phase_end, run, reject, pulse_start, pulse_end, rest_nz;
    logic [2:0]           nz_cga;
    logic [CNT_WIDTH-1:0] phase_len;
    state_t               nxt_mid, nxt_first;

    assign nz_cga  = {anod_q != '0, gap_q != '0, cath_q != '0};
    assign rest_nz = (rest_q != '0);
    assign run     = (state_q == ST_CATH) || (state_q == ST_GAP) ||
                     (state_q == ST_ANOD) || (state_q == ST_REST);

    always_comb begin
        phase_len = rest_q;
        case (state_q)
            ST_CATH: phase_len = cath_q;
            ST_GAP:  phase_len = gap_q;
            ST_ANOD: phase_len = anod_q;
            default: phase_len = rest_q;
        endcase
    end

    pulse_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .run       (run),
        .len       (phase_len),
        .tick      (tick),
        .phase_end (phase_end)
    );

`ifdef PULSE_SEQ_CHARGE_BAL_EN
    assign reject = (cath_len != anod_len);
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cath_d      = cath_q;
        gap_d       = gap_q;
        anod_d      = anod_q;
        rest_d      = rest_q;
        n_d         = n_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pulse_start = 1'b0;
        pulse_end   = 1'b0;
        nxt_mid     = ST_IDLE;
        nxt_first   = ST_IDLE;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && reject) begin
                        err_d = 1'b1;
                    end else if (start) begin
                        cath_d = cath_len;
                        gap_d  = gap_len;
                        anod_d = anod_len;
                        rest_d = rest_len;
                        n_d    = n_pulses;
                        idx_d  = '0;
                        if (n_pulses == '0) done_d  = 1'b1;
                        else                state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tick) begin
                        // All-zero train: every pulse takes zero time, so finish on this tick.
                        if (nz_cga == 3'b000 && !rest_nz) begin
                            idx_d   = n_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            pulse_start = 1'b1;
                        end
                    end
                end
                ST_CATH, ST_GAP: begin
                    if (phase_end) begin
                        nxt_mid = first_active(nz_cga, (state_q == ST_CATH) ? 2'd1 : 2'd2);
                        if (nxt_mid == ST_IDLE) pulse_end = 1'b1;
                        else                    state_d   = nxt_mid;
                    end
                end
                ST_ANOD: pulse_end   = phase_end;
                ST_REST: pulse_start = phase_end;
                default: state_d     = ST_IDLE;
            endcase

            if (pulse_start) begin
                nxt_first = first_active(nz_cga, 2'd0);
                if (nxt_first == ST_IDLE) pulse_end = 1'b1;
                else                      state_d   = nxt_first;
            end

            // Pulse boundary: REST is only used between pulses, never after the last.
            if (pulse_end) begin
                idx_d = idx_q + NP_WIDTH'(1);
                if (idx_d == n_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (rest_nz) begin
                    state_d = ST_REST;
                end else begin
                    state_d = first_active(nz_cga, 2'd0);
                end
            end
        end

        busy_d    = (state_d != ST_IDLE);
        cath_en_d = (state_d == ST_CATH);
        anod_en_d = (state_d == ST_ANOD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cath_q    <= '0;
            gap_q     <= '0;
            anod_q    <= '0;
            rest_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cath_en_q <= 1'b0;
            anod_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cath_q    <= cath_d;
            gap_q     <= gap_d;
            anod_q    <= anod_d;
            rest_q    <= rest_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cath_en_q <= cath_en_d;
            anod_en_q <= anod_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cath_en   = cath_en_q;
    assign anod_en   = anod_en_q;
    assign pulse_idx = idx_q;

endmodule
